// File: rtl/servo_pkg.sv
// servo_pkg: SG90 pulse scale and decoder FSM states shared by servo encode/decode blocks
package servo_pkg;
  localparam int SG90_MIN_TICKS = 45;
  localparam int SG90_MAX_TICKS = 225;
  localparam int SG90_ANGLE_MAX = 180;
  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} sg90_state_e;
endpackage

// File: rtl/pwm_in_sync.sv
// pwm_in_sync: 2-FF synchronizer plus registered rise/fall strobes
module pwm_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic rise,
  output logic fall
);
  logic [2:0] sr;
  // Sync stages keep tracking the pin through reset so a pulse already high at release gives no rise
  always_ff @(posedge clk) sr <= {sr[1:0], pwm_in};
  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= sr[1] & ~sr[2];
      fall <= ~sr[1] & sr[2];
    end
  end
endmodule

// File: rtl/sg90_decoder.sv
// sg90_decoder: measures servo PWM high time in 90 kHz ticks and recovers the 0..180 angle code
module sg90_decoder
  import servo_pkg::*;
#(
  parameter int MIN_TICKS     = SG90_MIN_TICKS,
  parameter int MAX_TICKS     = SG90_MAX_TICKS,
  parameter int TOL_TICKS     = 9,
  parameter int TIMEOUT_TICKS = 2700,
  parameter int CNT_W         = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_90khz,
  input  logic       pwm_in,
  output logic [7:0] angle,
  output logic       angle_valid,
  output logic       frame_err,
  output logic       lost
);
  localparam logic [CNT_W-1:0] W_LO = CNT_W'(MIN_TICKS - TOL_TICKS);
  localparam logic [CNT_W-1:0] W_HI = CNT_W'(MAX_TICKS + TOL_TICKS);
  localparam logic [CNT_W-1:0] W_MIN = CNT_W'(MIN_TICKS);
  localparam logic [CNT_W-1:0] W_MAX = CNT_W'(MAX_TICKS);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT_TICKS - 1);
  logic rise, fall, w_ok;
  logic [CNT_W-1:0] wcnt, pcnt, w_clamp;
  sg90_state_e state;
  pwm_in_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .rise   (rise),
    .fall   (fall)
  );
  always_comb begin
    w_ok = (wcnt >= W_LO) && (wcnt <= W_HI);
    w_clamp = wcnt < W_MIN ? W_MIN : wcnt > W_MAX ? W_MAX : wcnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wcnt        <= '0;
      pcnt        <= '0;
      angle       <= '0;
      angle_valid <= 1'b0;
      frame_err   <= 1'b0;
      lost        <= 1'b1;
    end else begin
      angle_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        ST_IDLE: if (rise) begin
          wcnt  <= '0;
          pcnt  <= '0;
          state <= ST_HIGH;
        end
        ST_HIGH: if (fall) begin
          state <= ST_LOW;
          if (w_ok) begin
            angle       <= 8'(w_clamp - W_MIN);
            angle_valid <= 1'b1;
            lost        <= 1'b0;
          end else frame_err <= 1'b1;
        end else if (tick_90khz) begin
          wcnt <= wcnt + 1'b1;
          pcnt <= pcnt + 1'b1;
          // Tick that pushes the width past the tolerance window means a stuck-high input
          if (wcnt == W_HI) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_LOW: if (rise) begin
          wcnt  <= '0;
          pcnt  <= '0;
          state <= ST_HIGH;
        end else if (tick_90khz) begin
          pcnt <= pcnt + 1'b1;
          if (pcnt == T_LAST) begin
            lost  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
